// File: rtl/p_ex_muldiv.sv
// Multi-cycle RV32M multiply/divide execute unit: pipelined multiplier plus restoring radix-2 divider.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the divide iterations.
//
// state  | meaning
// IDLE   | waiting for a request
// MUL    | product travelling through the multiplier pipe
// DIV    | one quotient bit per cycle on absolute values
// FIX    | sign correction and RISC-V special-case results
// DONE   | write-back record valid for one cycle
module p_ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            start_in,
    input  logic            flush_in,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] op1_in,
    input  logic [XLEN-1:0] op2_in,
    input  logic [4:0]      w_addr_in,
    output logic            busy_out,
    output logic            done_out,
    output logic            out_we,
    output logic [4:0]      out_w_addr,
    output logic [XLEN-1:0] out_w_data
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_r;
    logic [XLEN-1:0]   a_r, b_r;
    logic [XLEN-1:0]   quo, rem, dvs;
    logic [2*XLEN-1:0] pipe [MUL_STAGES];

    logic              accept;
    logic              a_sx, b_sx, div_signed;
    logic [2*XLEN-1:0] a_wide, b_wide, product;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              special_in;
    logic [XLEN:0]     shifted, diff;
    logic              take;
    logic              div0, ovf, neg_q, neg_r;
    logic [XLEN-1:0]   q_fix, r_fix, fix_result, mul_result;

    always_comb begin
        accept     = rdy_in && start_in && !flush_in && (state == S_IDLE || state == S_DONE);
        // Sign-extending to 2*XLEN makes one unsigned multiply serve all three signedness modes.
        a_sx       = (op_in == 3'd1 || op_in == 3'd2) && op1_in[XLEN-1];
        b_sx       = (op_in == 3'd1) && op2_in[XLEN-1];
        a_wide     = {{XLEN{a_sx}}, op1_in};
        b_wide     = {{XLEN{b_sx}}, op2_in};
        product    = a_wide * b_wide;
        div_signed = !op_in[0];
        a_abs      = (div_signed && op1_in[XLEN-1]) ? -op1_in : op1_in;
        b_abs      = (div_signed && op2_in[XLEN-1]) ? -op2_in : op2_in;
        special_in = EARLY_OUT && ((op2_in == '0) ||
                     (div_signed && op1_in == SMIN && op2_in == '1));
        shifted    = {rem, quo[XLEN-1]};
        take       = shifted >= {1'b0, dvs};
        diff       = shifted - {1'b0, dvs};
        div0       = (b_r == '0);
        ovf        = !op_r[0] && a_r == SMIN && b_r == '1;
        neg_q      = !op_r[0] && (a_r[XLEN-1] ^ b_r[XLEN-1]);
        neg_r      = !op_r[0] && a_r[XLEN-1];
        q_fix      = neg_q ? -quo : quo;
        r_fix      = neg_r ? -rem : rem;
        if (div0)
            fix_result = op_r[1] ? a_r : '1;
        else if (ovf)
            fix_result = op_r[1] ? '0 : a_r;
        else
            fix_result = op_r[1] ? r_fix : q_fix;
        mul_result = (op_r[1:0] == 2'd0) ? pipe[MUL_STAGES-1][XLEN-1:0]
                                         : pipe[MUL_STAGES-1][2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < MUL_STAGES; i++) pipe[i] <= '0;
        end else if (rdy_in) begin
            if (accept) pipe[0] <= product;
            for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            out_we     <= 1'b0;
            out_w_addr <= '0;
            out_w_data <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                state      <= S_IDLE;
                cnt        <= '0;
                busy_out   <= 1'b0;
                done_out   <= 1'b0;
                out_we     <= 1'b0;
                out_w_addr <= '0;
                out_w_data <= '0;
            end else if (accept) begin
                op_r       <= op_in;
                a_r        <= op1_in;
                b_r        <= op2_in;
                quo        <= a_abs;
                rem        <= '0;
                dvs        <= b_abs;
                cnt        <= '0;
                out_w_addr <= w_addr_in;
                busy_out   <= 1'b1;
                done_out   <= 1'b0;
                out_we     <= 1'b0;
                if (!op_in[2])
                    state <= S_MUL;
                else if (special_in)
                    state <= S_FIX;
                else
                    state <= S_DIV;
            end else begin
                case (state)
                    S_IDLE: ;
                    S_MUL: begin
                        if (cnt == CW'(MUL_STAGES - 1)) begin
                            state      <= S_DONE;
                            busy_out   <= 1'b0;
                            done_out   <= 1'b1;
                            out_we     <= (out_w_addr != 5'd0);
                            out_w_data <= mul_result;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DIV: begin
                        rem <= take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], take};
                        if (cnt == CW'(XLEN - 1))
                            state <= S_FIX;
                        else
                            cnt <= cnt + CW'(1);
                    end
                    S_FIX: begin
                        state      <= S_DONE;
                        busy_out   <= 1'b0;
                        done_out   <= 1'b1;
                        out_we     <= (out_w_addr != 5'd0);
                        out_w_data <= fix_result;
                    end
                    S_DONE: begin
                        state    <= S_IDLE;
                        done_out <= 1'b0;
                        out_we   <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_p_ex_muldiv.sv
// Self-checking bench for p_ex_muldiv: issued requests push expected results into a scoreboard,
// a negedge monitor pops and compares on every fresh done_out pulse.
module tb_p_ex_muldiv;
    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in, start_in, flush_in;
    logic [2:0]       op_in;
    logic [XLEN-1:0]  op1_in, op2_in;
    logic [4:0]       w_addr_in;
    logic             busy_out, done_out, out_we;
    logic [4:0]       out_w_addr;
    logic [XLEN-1:0]  out_w_data;

    always #5 clk_in = ~clk_in;

    p_ex_muldiv #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .start_in(start_in),
        .flush_in(flush_in), .op_in(op_in), .op1_in(op1_in), .op2_in(op2_in),
        .w_addr_in(w_addr_in), .busy_out(busy_out), .done_out(done_out),
        .out_we(out_we), .out_w_addr(out_w_addr), .out_w_data(out_w_data)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, want);
        end
    endtask

    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb_, ua, ub, p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (op)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb_; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return MUL_STAGES;
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
`endif
        return XLEN + 1;
    endfunction

    // Called just after a rising edge; the request is accepted at the next edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input bit expect_it, input int extra);
        exp_t e;
        start_in  = 1'b1;
        op_in     = op;
        op1_in    = a;
        op2_in    = b;
        w_addr_in = wa;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        if (expect_it) begin
            e.data = model_result(op, a, b);
            e.addr = wa;
            e.cyc  = cyc + latency(op, a, b) + extra;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done_out && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        chk(name, 32'(done_out), 32'd1);
    endtask

    initial begin
        bit   prev_done;
        bit   prev_rdy;
        exp_t e;
        prev_done = 1'b0;
        prev_rdy  = 1'b1;
        forever begin
            @(negedge clk_in);
            if (done_out && !(prev_done && !prev_rdy)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done actual=done_out=1 required=no pending result");
                end else begin
                    e = sb.pop_front();
                    chk("data", out_w_data, e.data);
                    chk("addr", 32'(out_w_addr), 32'(e.addr));
                    chk("we", 32'(out_we), 32'(e.addr != 5'd0));
                    chk("latency", cyc, e.cyc);
                end
            end
            prev_done = done_out;
            prev_rdy  = rdy_in;
        end
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        start_in  = 1'b0;
        flush_in  = 1'b0;
        op_in     = '0;
        op1_in    = '0;
        op2_in    = '0;
        w_addr_in = '0;
        #1;
        chk("reset_busy", 32'(busy_out), 32'd0);
        chk("reset_done", 32'(done_out), 32'd0);
        chk("reset_we", 32'(out_we), 32'd0);
        chk("reset_addr", 32'(out_w_addr), 32'd0);
        chk("reset_data", out_w_data, 32'd0);
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // multiplies, the second and third issued in the DONE cycle
        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 0);
        chk("mul_busy", 32'(busy_out), 32'd1);
        wait_done("mul_done");
        issue(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 0);
        wait_done("mulhu_done");
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd5, 1'b1, 0);
        wait_done("mulh_done");

        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 0);
        chk("div_busy", 32'(busy_out), 32'd1);
        wait_done("div_done");
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd3, 1'b1, 0);
        wait_done("rem_done");
        issue(3'd5, 32'h8000_0000, 32'd3, 5'd4, 1'b1, 0);
        wait_done("divu_done");
        issue(3'd4, 32'd5, 32'd0, 5'd6, 1'b1, 0);
        wait_done("div0_done");
        issue(3'd6, 32'd5, 32'd0, 5'd6, 1'b1, 0);
        wait_done("rem0_done");
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 0);
        wait_done("ovf_div_done");
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, 0);
        wait_done("ovf_rem_done");
        @(posedge clk_in);
        #1;

        // flush on the tenth cycle of a divide
        issue(3'd4, 32'd12345, 32'd17, 5'd8, 1'b0, 0);
        repeat (9) begin
            @(posedge clk_in);
            #1;
        end
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        chk("flush_busy", 32'(busy_out), 32'd0);
        chk("flush_done", 32'(done_out), 32'd0);
        issue(3'd0, 32'd1234, 32'd5678, 5'd9, 1'b1, 0);
        wait_done("after_flush_done");
        @(posedge clk_in);
        #1;

        // enable low for 3 cycles mid-divide, then again while the result is presented
        issue(3'd4, 32'd1000, 32'd7, 5'd10, 1'b1, 3);
        repeat (5) begin
            @(posedge clk_in);
            #1;
        end
        rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rdy_in = 1'b1;
        wait_done("stall_done");
        rdy_in = 1'b0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            chk("hold_done", 32'(done_out), 32'd1);
            chk("hold_data", out_w_data, 32'd142);
        end
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("release_done", 32'(done_out), 32'd0);

        // asynchronous reset in the middle of a multiply
        issue(3'd0, 32'd77, 32'd3, 5'd11, 1'b0, 0);
        chk("pre_reset_busy", 32'(busy_out), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_out), 32'd0);
        chk("arst_addr", 32'(out_w_addr), 32'd0);
        chk("arst_done", 32'(done_out), 32'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        issue(3'd0, 32'd6, 32'd7, 5'd0, 1'b1, 0);
        wait_done("waddr0_done");

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin
                    a = 32'($urandom_range(0, 40)) - 32'd20;
                    b = 32'($urandom_range(0, 10)) - 32'd5;
                end
                default: ;
            endcase
            issue(op, a, b, 5'($urandom_range(0, 31)), 1'b1, 0);
            wait_done("rand_done");
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk_in);
                    #1;
                end
            end
        end

        repeat (3) @(posedge clk_in);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
